pmem_arbiter: RTL and testbench

Parametrised physical-memory arbiter that multiplexes `NUM_PORTS` cache-line requesters (I-cache, D-cache, prefetcher) onto the single 256-bit pmem port of the `mp2` top level. It sits between the cache instances and physical memory and replaces the one-cache-to-pmem direct connection. Each transaction is serviced completely, one at a time, using round-robin or fixed-priority selection. Each requester receives a one-cycle response pulse with registered read data.

---
 rtl/pmem_arbiter_pkg.sv | 22 ++
 rtl/pmem_arbiter_if.sv | 36 +++
 rtl/pmem_arb_picker.sv | 30 +++
 rtl/pmem_arbiter.sv | 128 ++++++++++++
 tb/tb_pmem_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the pmem arbiter: FSM states, memory op and sizing helpers.
package pmem_arb_types;

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Requester-side and memory-side buses of the pmem arbiter bundled in one interface.
interface pmem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                 req_read;
    logic [NUM_PORTS-1:0]                 req_write;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]                req_rdata;
    logic [NUM_PORTS-1:0]                 req_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Arbiter view: serves the requesters, drives physical memory.
    modport master (
        input  req_read, req_write, req_address, req_wdata,
        output req_rdata, req_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment view: caches and physical memory.
    modport slave (
        output req_read, req_write, req_address, req_wdata,
        input  req_rdata, req_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arb_picker.sv
// Combinational winner picker: first pending port at or above ptr, wrapping.
module pmem_arb_picker
    import pmem_arb_types::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     winner
);

    int unsigned k;

    // NOTE: every output gets a default before the search so no path can infer a latch.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        k      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(ptr) + i) % NUM_PORTS;
            if (!valid && pending[k]) begin
                valid  = 1'b1;
                winner = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Multiplexes NUM_PORTS cache-line requesters onto one pmem port, one transaction at a time.
// Define PMEM_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    pmem_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    arb_state_t            state, state_d;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      pick_ptr;
    logic [IDX_W-1:0]      winner;
    logic                  pick_valid;
    logic [NUM_PORTS-1:0]  pending;
    pmem_op_t              pick_op;

    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [NUM_PORTS-1:0]  resp_q, resp_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;

    assign pending = bus.req_read | bus.req_write;
    // Read and write together is illegal; write wins.
    assign pick_op = bus.req_write[winner] ? OP_WRITE : OP_READ;

`ifdef PMEM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == RESP) begin
            rr_ptr <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = '0;
`endif

    pmem_arb_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .pending (pending),
        .ptr     (pick_ptr),
        .valid   (pick_valid),
        .winner  (winner)
    );

    always_comb begin
        state_d = state;
        read_d  = read_q;
        write_d = write_q;
        resp_d  = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    read_d  = (pick_op == OP_READ);
                    write_d = (pick_op == OP_WRITE);
                end
            end
            BUSY: begin
                if (bus.pmem_resp) begin
                    state_d           = RESP;
                    read_d            = 1'b0;
                    write_d           = 1'b0;
                    resp_d[grant_idx] = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= '0;
            // NOTE: the wide data registers are reset too, so every output reads 0 out of reset.
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state   <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            if (state == IDLE && pick_valid) begin
                grant_idx <= winner;
                addr_q    <= bus.req_address[winner];
                wdata_q   <= bus.req_wdata[winner];
            end
            if (state == BUSY && bus.pmem_resp) begin
                rdata_q <= bus.pmem_rdata;
            end
        end
    end

    assign bus.pmem_read    = read_q;
    assign bus.pmem_write   = write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.req_rdata    = rdata_q;
    assign bus.req_resp     = resp_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;

    localparam int NP = 2;
    localparam int LW = 256;
    localparam int AW = 32;

`ifdef PMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pmem_arbiter_if #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    pmem_arbiter #(
        .NUM_PORTS  (NP),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit              active;
        bit              rd;
        bit              wr;
        logic [AW-1:0]   addr;
        logic [LW-1:0]   data;
    } port_req_t;

    port_req_t pr [NP];
    int        rr     = 0;
    int        checks = 0;
    int        errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] fill_line(input logic [7:0] b);
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 8; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    task automatic drive_ports();
        for (int i = 0; i < NP; i++) begin
            bus.req_read[i]    = pr[i].active && pr[i].rd;
            bus.req_write[i]   = pr[i].active && pr[i].wr;
            bus.req_address[i] = pr[i].addr;
            bus.req_wdata[i]   = pr[i].data;
        end
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr,
                            input logic [AW-1:0] addr, input logic [LW-1:0] data);
        pr[p].active = 1'b1;
        pr[p].rd     = rd;
        pr[p].wr     = wr;
        pr[p].addr   = addr;
        pr[p].data   = data;
    endtask

    // Arbitration rule: first pending port at or above the start point, wrapping.
    function automatic int model_pick();
        int start;
        start = RR_EN ? rr : 0;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (start + i) % NP;
            if (pr[p].active) return p;
        end
        return -1;
    endfunction

    // Entered and left at a falling edge while the arbiter sits in IDLE.
    task automatic do_txn(input int lat, input logic [LW-1:0] line,
                          input bit drop_mid, input bit perturb);
        int            w;
        bit            wr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ed;
        logic [NP-1:0] exp_resp;

        w = model_pick();
        // Memory noise while idle must be ignored.
        bus.pmem_resp  = 1'($urandom_range(0, 1));
        bus.pmem_rdata = rand_line();
        if (w < 0) begin
            @(posedge clk); @(negedge clk);
            check("idle_read",  bus.pmem_read,  1'b0);
            check("idle_write", bus.pmem_write, 1'b0);
            check("idle_resp",  bus.req_resp,   '0);
            return;
        end
        wr = pr[w].wr;
        ea = pr[w].addr;
        ed = pr[w].data;
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= lat; c++) begin
            check("busy_read",  bus.pmem_read,    !wr);
            check("busy_write", bus.pmem_write,   wr);
            check("busy_addr",  bus.pmem_address, ea);
            check("busy_wdata", bus.pmem_wdata,   ed);
            check("busy_resp",  bus.req_resp,     '0);
            if (c == 1 && perturb) begin
                pr[w].addr = $urandom;
                pr[w].data = rand_line();
            end
            if (c == 1 && drop_mid) pr[w].active = 1'b0;
            drive_ports();
            bus.pmem_resp  = (c == lat);
            bus.pmem_rdata = (c == lat) ? line : rand_line();
            @(posedge clk); @(negedge clk);
        end
        bus.pmem_resp = 1'b0;
        exp_resp      = '0;
        exp_resp[w]   = 1'b1;
        check("resp_onehot", bus.req_resp,   exp_resp);
        check("resp_rdata",  bus.req_rdata,  line);
        check("resp_read",   bus.pmem_read,  1'b0);
        check("resp_write",  bus.pmem_write, 1'b0);
        rr           = (w + 1) % NP;
        pr[w].active = 1'b0;
        drive_ports();
        @(posedge clk); @(negedge clk);
        check("after_resp",  bus.req_resp,   '0);
        check("after_read",  bus.pmem_read,  1'b0);
        check("after_write", bus.pmem_write, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    // NOTE: stimulus is driven with blocking assignments at the falling edge, away from sampling.
    initial begin
        rst = 1'b1;
        for (int i = 0; i < NP; i++) begin
            pr[i].active = 1'b0; pr[i].rd = 1'b0; pr[i].wr = 1'b0;
            pr[i].addr = '0; pr[i].data = '0;
        end
        drive_ports();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read",  bus.pmem_read,    1'b0);
        check("rst_write", bus.pmem_write,   1'b0);
        check("rst_resp",  bus.req_resp,     '0);
        check("rst_addr",  bus.pmem_address, '0);
        check("rst_wdata", bus.pmem_wdata,   '0);
        check("rst_rdata", bus.req_rdata,    '0);
        rst = 1'b0;
        rr  = 0;

        // Single read, memory answers in the 4th BUSY cycle.
        set_port(0, 1'b1, 1'b0, 32'h0000_1000, rand_line());
        drive_ports();
        do_txn(4, fill_line(8'hAA), 1'b0, 1'b0);

        // Two simultaneous pairs, losers held.
        repeat (2) begin
            set_port(0, 1'b1, 1'b0, 32'h0000_3000, rand_line());
            set_port(1, 1'b1, 1'b0, 32'h0000_4000, rand_line());
            drive_ports();
            do_txn(2, rand_line(), 1'b0, 1'b0);
            do_txn(1, rand_line(), 1'b0, 1'b0);
        end

        // Write with the requester changing its address mid-BUSY.
        set_port(1, 1'b0, 1'b1, 32'h0000_2040, fill_line(8'h55));
        drive_ports();
        do_txn(3, rand_line(), 1'b0, 1'b1);

        // Illegal read+write on one port: write wins.
        set_port(0, 1'b1, 1'b1, 32'h0000_5000, rand_line());
        drive_ports();
        do_txn(2, rand_line(), 1'b0, 1'b0);

        // Port 0 re-requests continuously while port 1 waits.
        for (int t = 0; t < 10; t++) begin
            set_port(0, 1'b1, 1'b0, $urandom, rand_line());
            if (!pr[1].active) set_port(1, 1'b1, 1'b0, 32'h0000_6000, rand_line());
            drive_ports();
            do_txn($urandom_range(1, 3), rand_line(), 1'b0, 1'b0);
        end
        pr[0].active = 1'b0;
        pr[1].active = 1'b0;
        drive_ports();
        @(posedge clk); @(negedge clk);

        // Reset during the 2nd BUSY cycle of a read.
        set_port(0, 1'b1, 1'b0, 32'h0000_7000, rand_line());
        drive_ports();
        bus.pmem_resp = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rstmid_busy1", bus.pmem_read, 1'b1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rstmid_read",  bus.pmem_read, 1'b0);
        check("rstmid_resp",  bus.req_resp,  '0);
        check("rstmid_rdata", bus.req_rdata, '0);
        rst          = 1'b0;
        rr           = 0;
        pr[0].active = 1'b0;
        set_port(1, 1'b1, 1'b0, 32'h0000_8000, rand_line());
        drive_ports();
        do_txn(2, rand_line(), 1'b0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pr[i].active && $urandom_range(0, 2) != 0) begin
                    int op;
                    op = $urandom_range(1, 3);
                    set_port(i, op[0], op[1], $urandom, rand_line());
                end
            end
            drive_ports();
            do_txn($urandom_range(1, 5), rand_line(),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
